// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for a single external 1-bit ALU slice: decodes ALUOp/funct,
// streams operands LSB first over WIDTH cycles and assembles the result and flags.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             illegal,
    output logic [3:0]       slice_ctl,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_c_in,
    output logic             slice_slt,
    input  logic             slice_out,
    input  logic             slice_c_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_SLT = 4'd7;
    localparam logic [3:0] CTL_NOR = 4'd12;
    localparam logic [3:0] CTL_ILL = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic             run_s;
    logic             last_s;
    logic [3:0]       dec_ctl_s;
    logic             slt_bit_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] final_s;

    function automatic logic [3:0] decode_ctl(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] ctl;
        case (op)
            2'b00:   ctl = CTL_ADD;
            2'b01:   ctl = CTL_SUB;
            2'b10: begin
                case (f)
                    6'b100000: ctl = CTL_ADD;
                    6'b100010: ctl = CTL_SUB;
                    6'b100100: ctl = CTL_AND;
                    6'b100101: ctl = CTL_OR;
                    6'b101010: ctl = CTL_SLT;
                    6'b100111: ctl = CTL_NOR;
                    default:   ctl = CTL_ILL;
                endcase
            end
            default: ctl = CTL_ILL;
        endcase
        return ctl;
    endfunction

    assign run_s      = (state_r == ST_RUN);
    assign last_s     = run_s && (cnt_r == CW'(WIDTH - 1));
    assign dec_ctl_s  = decode_ctl(alu_op, funct);
    assign in_ready   = (state_r == ST_IDLE);
    assign out_valid  = (state_r == ST_DONE);
    assign slice_a    = run_s & a_sh_r[0];
    assign slice_b    = run_s & b_sh_r[0];
    assign slice_c_in = run_s & c_r;
    assign slice_slt  = 1'b0;

    // Final result: slt takes the sign of A-B from the MSB cycle, illegal forces zero.
    always_comb begin
        shifted_s = {slice_out, res_sh_r[WIDTH-1:1]};
        slt_bit_s = a_sh_r[0] ^ ~b_sh_r[0] ^ c_r;
        final_s   = shifted_s;
        case (slice_ctl)
            CTL_SLT: final_s = {{(WIDTH-1){1'b0}}, slt_bit_s};
            CTL_ILL: final_s = {WIDTH{1'b0}};
            default: final_s = shifted_s;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Operand/result shifters, carry flop, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r    <= {WIDTH{1'b0}};
            b_sh_r    <= {WIDTH{1'b0}};
            res_sh_r  <= {WIDTH{1'b0}};
            c_r       <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            slice_ctl <= 4'd0;
            result    <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            carry     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_r    <= op_a;
                        b_sh_r    <= op_b;
                        res_sh_r  <= {WIDTH{1'b0}};
                        c_r       <= (dec_ctl_s == CTL_SUB) || (dec_ctl_s == CTL_SLT);
                        cnt_r     <= {CW{1'b0}};
                        slice_ctl <= dec_ctl_s;
                        result    <= {WIDTH{1'b0}};
                        zero      <= 1'b0;
                        carry     <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    res_sh_r <= shifted_s;
                    c_r      <= slice_c_out;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        result  <= final_s;
                        zero    <= (final_s == {WIDTH{1'b0}});
                        carry   <= ((slice_ctl == CTL_ADD) || (slice_ctl == CTL_SUB)) ? slice_c_out : 1'b0;
                        illegal <= (slice_ctl == CTL_ILL);
                    end
                end
                default: begin
                    result <= result;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed scoreboard bench for alu_serial_seq: two instances (WIDTH=8 and 32),
// each driving a behavioural 1-bit slice.
module tb_alu_serial_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel8;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        in_ready8, out_valid8, zero8, carry8, illegal8;
    logic        sa8, sb8, sc8, sslt8, so8, sco8;
    logic [7:0]  res8;
    logic [3:0]  sctl8;
    logic        in_ready32, out_valid32, zero32, carry32, illegal32;
    logic        sa32, sb32, sc32, sslt32, so32, sco32;
    logic [31:0] res32;
    logic [3:0]  sctl32;

    logic        cur_ready, cur_valid, cur_zero, cur_carry, cur_illegal, cur_cin;
    logic [31:0] cur_result;
    logic [3:0]  cur_ctl;
    logic        first_cin;
    logic [3:0]  first_ctl;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        carry;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel8), .in_ready(in_ready8),
        .alu_op(alu_op), .funct(funct), .op_a(op_a[7:0]), .op_b(op_b[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready & sel8), .result(res8),
        .zero(zero8), .carry(carry8), .illegal(illegal8), .slice_ctl(sctl8),
        .slice_a(sa8), .slice_b(sb8), .slice_c_in(sc8), .slice_slt(sslt8),
        .slice_out(so8), .slice_c_out(sco8)
    );

    alu_serial_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel8), .in_ready(in_ready32),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid32), .out_ready(out_ready & ~sel8), .result(res32),
        .zero(zero32), .carry(carry32), .illegal(illegal32), .slice_ctl(sctl32),
        .slice_a(sa32), .slice_b(sb32), .slice_c_in(sc32), .slice_slt(sslt32),
        .slice_out(so32), .slice_c_out(sco32)
    );

    // Behavioural slice: returns {carry_out, result_bit}.
    function automatic logic [1:0] slice_fn(input logic [3:0] ctl, input logic a, input logic b,
                                            input logic c, input logic slt);
        logic nb;
        nb = ~b;
        case (ctl)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
            4'd6:    return {(a & nb) | (a & c) | (nb & c), a ^ nb ^ c};
            4'd7:    return {(a & nb) | (a & c) | (nb & c), slt};
            4'd12:   return {1'b0, ~(a | b)};
            default: return 2'b00;
        endcase
    endfunction

    assign {sco8, so8}   = slice_fn(sctl8, sa8, sb8, sc8, sslt8);
    assign {sco32, so32} = slice_fn(sctl32, sa32, sb32, sc32, sslt32);

    always_comb begin
        if (sel8) begin
            cur_ready = in_ready8;  cur_valid = out_valid8;  cur_zero = zero8;
            cur_carry = carry8;     cur_illegal = illegal8;  cur_cin = sc8;
            cur_result = {24'h0, res8}; cur_ctl = sctl8;
        end else begin
            cur_ready = in_ready32; cur_valid = out_valid32; cur_zero = zero32;
            cur_carry = carry32;    cur_illegal = illegal32; cur_cin = sc32;
            cur_result = res32;     cur_ctl = sctl32;
        end
    end

    // Word-level reference model.
    function automatic exp_t model(input int w, input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] mask;
        logic [32:0] wide;
        logic [31:0] am, bm, d;
        int          kind;
        mask = (33'd1 << w) - 33'd1;
        am = a & mask[31:0];
        bm = b & mask[31:0];
        e.result = 32'h0; e.carry = 1'b0; e.illegal = 1'b0;
        kind = 0;
        if (op == 2'b00) kind = 1;
        else if (op == 2'b01) kind = 2;
        else if (op == 2'b10) begin
            if (f == 6'h20) kind = 1;
            else if (f == 6'h22) kind = 2;
            else if (f == 6'h24) kind = 3;
            else if (f == 6'h25) kind = 4;
            else if (f == 6'h2A) kind = 5;
            else if (f == 6'h27) kind = 6;
            else kind = 0;
        end else kind = 0;
        case (kind)
            1: begin wide = {1'b0, am} + {1'b0, bm}; e.result = wide[31:0] & mask[31:0]; e.carry = wide[w]; end
            2: begin wide = {1'b0, am} + {1'b0, ~bm & mask[31:0]} + 33'd1;
                     e.result = wide[31:0] & mask[31:0]; e.carry = wide[w]; end
            3: e.result = am & bm;
            4: e.result = am | bm;
            5: begin d = am - bm; e.result = {31'h0, d[w-1]}; end
            6: e.result = ~(am | bm) & mask[31:0];
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == 32'h0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit w8, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input string tag,
                          input int stall, input bit keep_valid);
        int   n;
        int   w;
        exp_t e;
        logic [31:0] hold;
        sel8 = w8;
        w = w8 ? 8 : 32;
        n = 0;
        while (!cur_ready && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, {31'h0, cur_ready}, 32'h1);
        alu_op = op; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
        sb_q.push_back(model(w, op, f, a, b));
        @(posedge clk); @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        first_cin = cur_cin;
        first_ctl = cur_ctl;
        n = 1;
        while (!cur_valid && n < 200) begin @(posedge clk); n++; @(negedge clk); end
        chk({tag, "_latency"}, n, w + 1);
        chk({tag, "_busy"}, {31'h0, cur_ready}, 32'h0);
        e = sb_q.pop_front();
        chk({tag, "_result"}, cur_result, e.result);
        chk({tag, "_zero"}, {31'h0, cur_zero}, {31'h0, e.zero});
        chk({tag, "_carry"}, {31'h0, cur_carry}, {31'h0, e.carry});
        chk({tag, "_illegal"}, {31'h0, cur_illegal}, {31'h0, e.illegal});
        hold = cur_result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, {31'h0, cur_valid}, 32'h1);
            chk({tag, "_stall_result"}, cur_result, e.result);
            chk({tag, "_stall_ready"}, {31'h0, cur_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_idle_ready"}, {31'h0, cur_ready}, 32'h1);
        chk({tag, "_idle_valid"}, {31'h0, cur_valid}, 32'h0);
        chk({tag, "_result_kept"}, cur_result, hold);
    endtask

    initial begin
        rst = 1'b1; sel8 = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct = 6'h00; op_a = 32'h0; op_b = 32'h0;
        first_cin = 1'b0; first_ctl = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst8_ready", {31'h0, cur_ready}, 32'h1);
        chk("rst8_valid", {31'h0, cur_valid}, 32'h0);
        chk("rst8_result", cur_result, 32'h0);
        chk("rst8_flags", {28'h0, cur_zero, cur_carry, cur_illegal, 1'b0}, 32'h0);
        chk("rst8_ctl", {28'h0, cur_ctl}, 32'h0);
        sel8 = 1'b0;
        #1;
        chk("rst32_ready", {31'h0, cur_ready}, 32'h1);
        chk("rst32_result", cur_result, 32'h0);

        run_op(1'b1, 2'b00, 6'h00, 32'h7F, 32'h01, "add8", 0, 1'b0);
        chk("add8_result_abs", cur_result, 32'h80);
        run_op(1'b1, 2'b01, 6'h00, 32'h05, 32'h05, "sub8", 0, 1'b0);
        chk("sub8_cin0", {31'h0, first_cin}, 32'h1);
        chk("sub8_zero_abs", {31'h0, cur_zero}, 32'h1);
        run_op(1'b1, 2'b10, 6'h2A, 32'hFE, 32'h03, "slt8_neg", 0, 1'b0);
        chk("slt8_neg_abs", cur_result, 32'h1);
        run_op(1'b1, 2'b10, 6'h2A, 32'h03, 32'hFE, "slt8_pos", 0, 1'b0);
        chk("slt8_pos_abs", cur_result, 32'h0);
        run_op(1'b1, 2'b00, 6'h00, 32'hFF, 32'h01, "add8_cout", 0, 1'b0);
        run_op(1'b0, 2'b10, 6'h27, 32'h0000FFFF, 32'h00FF0000, "nor32", 0, 1'b0);
        chk("nor32_abs", cur_result, 32'hFF000000);
        run_op(1'b0, 2'b10, 6'h24, 32'h0000FFFF, 32'h00FF0000, "and32", 0, 1'b0);
        run_op(1'b0, 2'b10, 6'h25, 32'h0000FFFF, 32'h00FF0000, "or32", 0, 1'b0);
        chk("or32_abs", cur_result, 32'h00FFFFFF);
        run_op(1'b0, 2'b10, 6'h22, 32'h00000003, 32'h00000005, "sub32", 0, 1'b0);
        run_op(1'b1, 2'b10, 6'h00, 32'h12, 32'h34, "ill8", 5, 1'b1);
        chk("ill8_ctl_run", {28'h0, first_ctl}, 32'hF);
        run_op(1'b1, 2'b11, 6'h20, 32'h01, 32'h01, "ill8_op", 0, 1'b0);

        // Reset in RUN cycle 3 abandons the operation.
        sel8 = 1'b1;
        alu_op = 2'b01; op_a = 32'hAA; op_b = 32'h55; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_ready", {31'h0, cur_ready}, 32'h1);
        chk("midrst_valid", {31'h0, cur_valid}, 32'h0);
        chk("midrst_result", cur_result, 32'h0);
        run_op(1'b1, 2'b00, 6'h00, 32'h0F, 32'h01, "add8_after_rst", 0, 1'b0);
        chk("add8_after_rst_abs", cur_result, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
